ringbuffer_fifo: RTL and testbench

//  Parametrised data-carrying ring buffer. Sits between the LPC capture front-end and the UART

---
 rtl/ringbuffer_pkg.sv | 14 +
 rtl/ringbuffer_fifo_mem.sv | 30 +++
 rtl/ringbuffer_fifo.sv | 152 +++++++++++++++
 tb/tb_ringbuffer_fifo.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ringbuffer_pkg.sv
// Shared definitions for the LPC-sniffer ring buffer: counter width,
// full-policy encodings and the pointer-width helper.
package ringbuffer_pkg;

  localparam int DROPCNT_W        = 16;
  localparam int POLICY_DROP      = 0;
  localparam int POLICY_OVERWRITE = 1;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  function automatic int ptr_w(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/ringbuffer_fifo_mem.sv
// Storage array for ringbuffer_fifo: DEPTH x DW registers, one synchronous
// write port and one asynchronous read port. Contents are never reset.
module ringbuffer_fifo_mem
  import ringbuffer_pkg::*;
#(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          write_enable,
  input  logic [AW-1:0] write_addr,
  input  logic [DW-1:0] write_word,
  input  logic [AW-1:0] read_addr,
  output logic [DW-1:0] read_word
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] store [DEPTH];

  // Capture the incoming word at the addressed slot.
  always_ff @(posedge clock) begin
    if (write_enable) begin
      store[write_addr] <= write_word;
    end
  end

  assign read_word = store[read_addr];

endmodule

// File: rtl/ringbuffer_fifo.sv
// Ring buffer between the LPC capture front-end and the UART drain path.
// Show-ahead read data, fill level, almost-full, sticky overflow and a
// selectable full-policy (drop newest / overwrite oldest).
// Optional feature: define RINGBUFFER_FIFO_DROPCNT_EN to add the saturating
// drop_count port and counter.
module ringbuffer_fifo
  import ringbuffer_pkg::*;
#(
  parameter int AW        = 4,
  parameter int DW        = 8,
  parameter int AF_LEVEL  = 12,
  parameter int OVERWRITE = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 write_clock_enable,
  input  logic [DW-1:0]        write_data,
  input  logic                 read_clock_enable,
  output logic [DW-1:0]        read_data,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_full,
  output logic [AW:0]          level,
  output logic                 overflow,
  input  logic                 clear_overflow
`ifdef RINGBUFFER_FIFO_DROPCNT_EN
  ,
  output logic [DROPCNT_W-1:0] drop_count
`endif
);

  localparam int            PW      = ptr_w(AW);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW-1:0] AF_THR  = PW'(AF_LEVEL);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_next;
  logic [PW-1:0] rd_next;
  logic [PW-1:0] level_next;
  logic          mem_we;
  logic          ovf_event;
  logic [DW-1:0] mem_rdata;

  ringbuffer_fifo_mem #(
    .AW (AW),
    .DW (DW)
  ) u_mem (
    .clock        (clock),
    .write_enable (mem_we),
    .write_addr   (wr_ptr[AW-1:0]),
    .write_word   (write_data),
    .read_addr    (rd_ptr[AW-1:0]),
    .read_word    (mem_rdata)
  );

  // Decide pointer movement, storage write and overflow event for this cycle.
  always_comb begin
    wr_next   = wr_ptr;
    rd_next   = rd_ptr;
    mem_we    = 1'b0;
    ovf_event = 1'b0;
    if (write_clock_enable && !full) begin
      mem_we  = 1'b1;
      wr_next = wr_ptr + PTR_ONE;
      if (read_clock_enable && !empty) begin
        rd_next = rd_ptr + PTR_ONE;
      end else begin
        rd_next = rd_ptr;
      end
    end else if (write_clock_enable) begin
      if (read_clock_enable) begin
        // Full with a simultaneous pop: a slot frees up, nothing is lost.
        mem_we  = 1'b1;
        wr_next = wr_ptr + PTR_ONE;
        rd_next = rd_ptr + PTR_ONE;
      end else begin
        ovf_event = 1'b1;
        if (OVERWRITE == POLICY_OVERWRITE) begin
          mem_we  = 1'b1;
          wr_next = wr_ptr + PTR_ONE;
          rd_next = rd_ptr + PTR_ONE;
        end else begin
          mem_we = 1'b0;
        end
      end
    end else if (read_clock_enable && !empty) begin
      rd_next = rd_ptr + PTR_ONE;
    end else begin
      rd_next = rd_ptr;
    end
    level_next = wr_next - rd_next;
  end

  // Pointer and flag registers; flags are computed from the next pointers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= {PW{1'b0}};
      rd_ptr      <= {PW{1'b0}};
      level       <= {PW{1'b0}};
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      wr_ptr      <= wr_next;
      rd_ptr      <= rd_next;
      level       <= level_next;
      empty       <= (wr_next == rd_next);
      full        <= (wr_next[AW] != rd_next[AW]) &&
                     (wr_next[AW-1:0] == rd_next[AW-1:0]);
      almost_full <= (level_next >= AF_THR);
    end
  end

  // Sticky overflow; a new overflow event beats a simultaneous clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (ovf_event) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end else begin
      overflow <= overflow;
    end
  end

`ifdef RINGBUFFER_FIFO_DROPCNT_EN
  localparam logic [DROPCNT_W-1:0] DC_MAX = {DROPCNT_W{1'b1}};
  localparam logic [DROPCNT_W-1:0] DC_ONE = DROPCNT_W'(1);

  // Saturating count of lost entries, cleared alongside overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      drop_count <= {DROPCNT_W{1'b0}};
    end else if (ovf_event) begin
      if (drop_count != DC_MAX) begin
        drop_count <= drop_count + DC_ONE;
      end else begin
        drop_count <= drop_count;
      end
    end else if (clear_overflow) begin
      drop_count <= {DROPCNT_W{1'b0}};
    end else begin
      drop_count <= drop_count;
    end
  end
`endif

  assign read_data = empty ? {DW{1'b0}} : mem_rdata;

endmodule

// File: tb/tb_ringbuffer_fifo.sv
// Self-checking bench for ringbuffer_fifo (AW=2, DW=8, AF_LEVEL=3).
// Two instances share stimulus: u0 drops on full, u1 overwrites the oldest.
// A queue-based reference model per instance supplies expected values.
module tb_ringbuffer_fifo;

  localparam int DEPTH = 4;
  localparam int AFL   = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       wce   = 1'b0;
  logic       rce   = 1'b0;
  logic       clr   = 1'b0;
  logic [7:0] wd    = 8'h00;

  logic [7:0] rd0, rd1;
  logic       e0, e1, f0, f1, af0, af1, o0, o1;
  logic [2:0] l0, l1;
`ifdef RINGBUFFER_FIFO_DROPCNT_EN
  logic [15:0] dc0, dc1;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] q [2][$];
  bit         mo [2];
  int         md [2];

  always #5 clock = ~clock;

  ringbuffer_fifo #(.AW(2), .DW(8), .AF_LEVEL(3), .OVERWRITE(0)) u0 (
    .clock(clock), .reset(reset), .write_clock_enable(wce), .write_data(wd),
    .read_clock_enable(rce), .read_data(rd0), .empty(e0), .full(f0),
    .almost_full(af0), .level(l0), .overflow(o0), .clear_overflow(clr)
`ifdef RINGBUFFER_FIFO_DROPCNT_EN
    , .drop_count(dc0)
`endif
  );

  ringbuffer_fifo #(.AW(2), .DW(8), .AF_LEVEL(3), .OVERWRITE(1)) u1 (
    .clock(clock), .reset(reset), .write_clock_enable(wce), .write_data(wd),
    .read_clock_enable(rce), .read_data(rd1), .empty(e1), .full(f1),
    .almost_full(af1), .level(l1), .overflow(o1), .clear_overflow(clr)
`ifdef RINGBUFFER_FIFO_DROPCNT_EN
    , .drop_count(dc1)
`endif
  );

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      q[k].delete();
      mo[k] = 1'b0;
      md[k] = 0;
    end
  endtask

  // Apply one clock edge to the reference model using the driven inputs.
  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      int n;
      bit evt;
      n = q[k].size();
      evt = 1'b0;
      if (wce && rce && n > 0) begin
        void'(q[k].pop_front());
        q[k].push_back(wd);
      end else if (wce && n < DEPTH) begin
        q[k].push_back(wd);
      end else if (wce) begin
        evt = 1'b1;
        if (k == 1) begin
          void'(q[k].pop_front());
          q[k].push_back(wd);
        end
      end else if (rce && n > 0) begin
        void'(q[k].pop_front());
      end
      if (evt) begin
        mo[k] = 1'b1;
        if (md[k] < 65535) md[k]++;
      end else if (clr) begin
        mo[k] = 1'b0;
        md[k] = 0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    model_update();
    #1;
  endtask

  function automatic logic [7:0] exp_head(int k);
    return (q[k].size() > 0) ? q[k][0] : 8'h00;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    model_clear();
    @(posedge clock);
    #1;
    checks++; if (e0 !== 1'b1) begin errors++; $display("FAIL rst_empty got=%0b exp=1", e0); end
    checks++; if (l0 !== 3'd0) begin errors++; $display("FAIL rst_level got=%0d exp=0", l0); end
    checks++; if (rd0 !== 8'h00) begin errors++; $display("FAIL rst_rdata got=%h exp=00", rd0); end
    checks++; if ({o0, f0, af0} !== 3'b000) begin errors++; $display("FAIL rst_flags got=%b exp=000", {o0, f0, af0}); end
    reset = 1'b1;
    rce = 1'b1;
    cycle();
    cycle();
    rce = 1'b0;
    checks++; if ({e0, e1} !== 2'b11) begin errors++; $display("FAIL pop_empty_empty got=%b exp=11", {e0, e1}); end
    checks++; if ({l0, l1} !== 6'd0) begin errors++; $display("FAIL pop_empty_level got=%0d/%0d exp=0/0", l0, l1); end
    checks++; if ({rd0, rd1} !== 16'h0000) begin errors++; $display("FAIL pop_empty_rdata got=%h/%h exp=00/00", rd0, rd1); end
    checks++; if ({o0, o1} !== 2'b00) begin errors++; $display("FAIL pop_empty_ovf got=%b exp=00", {o0, o1}); end
  endtask

  task automatic test_single();
    wce = 1'b1; wd = 8'hA1;
    cycle();
    wce = 1'b0;
    checks++; if (rd0 !== 8'hA1) begin errors++; $display("FAIL single_rdata got=%h exp=a1", rd0); end
    checks++; if (l0 !== 3'd1 || e0 !== 1'b0) begin errors++; $display("FAIL single_level got=%0d empty=%0b exp=1/0", l0, e0); end
    rce = 1'b1;
    cycle();
    rce = 1'b0;
    checks++; if (e0 !== 1'b1 || rd0 !== 8'h00) begin errors++; $display("FAIL single_pop got empty=%0b rd=%h exp=1/00", e0, rd0); end
  endtask

  task automatic test_fill();
    logic [7:0] seq [4];
    seq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    wce = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wd = seq[i];
      cycle();
    end
    checks++; if ({af0, af1} !== 2'b11) begin errors++; $display("FAIL fill_af got=%b exp=11", {af0, af1}); end
    checks++; if (l0 !== 3'd3 || f0 !== 1'b0) begin errors++; $display("FAIL fill_l3 got level=%0d full=%0b exp=3/0", l0, f0); end
    wd = seq[3];
    cycle();
    wce = 1'b0;
    checks++; if ({f0, f1} !== 2'b11) begin errors++; $display("FAIL fill_full got=%b exp=11", {f0, f1}); end
    checks++; if (l0 !== 3'd4 || l1 !== 3'd4) begin errors++; $display("FAIL fill_l4 got=%0d/%0d exp=4/4", l0, l1); end
  endtask

  task automatic test_full_policy();
    logic [7:0] exp0 [4];
    logic [7:0] exp1 [4];
    exp0 = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    exp1 = '{8'hA2, 8'hA3, 8'hA4, 8'hB5};
    wce = 1'b1; wd = 8'hB5;
    cycle();
    wce = 1'b0;
    checks++; if ({o0, o1} !== 2'b11) begin errors++; $display("FAIL policy_ovf got=%b exp=11", {o0, o1}); end
    checks++; if (l0 !== 3'd4 || l1 !== 3'd4) begin errors++; $display("FAIL policy_level got=%0d/%0d exp=4/4", l0, l1); end
`ifdef RINGBUFFER_FIFO_DROPCNT_EN
    checks++; if (dc0 !== 16'd1 || dc1 !== 16'd1) begin errors++; $display("FAIL policy_dropcnt got=%0d/%0d exp=1/1", dc0, dc1); end
`endif
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd0 !== exp0[i]) begin errors++; $display("FAIL drop_pop%0d got=%h exp=%h", i, rd0, exp0[i]); end
      checks++; if (rd1 !== exp1[i]) begin errors++; $display("FAIL overwrite_pop%0d got=%h exp=%h", i, rd1, exp1[i]); end
      rce = 1'b1;
      cycle();
      rce = 1'b0;
    end
    checks++; if ({e0, e1} !== 2'b11) begin errors++; $display("FAIL policy_drained got=%b exp=11", {e0, e1}); end
  endtask

  task automatic test_clear();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    checks++; if ({o0, o1} !== 2'b00) begin errors++; $display("FAIL clear_ovf got=%b exp=00", {o0, o1}); end
`ifdef RINGBUFFER_FIFO_DROPCNT_EN
    checks++; if (dc0 !== 16'd0 || dc1 !== 16'd0) begin errors++; $display("FAIL clear_dropcnt got=%0d/%0d exp=0/0", dc0, dc1); end
`endif
    wce = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wd = 8'hC0 + 8'(i);
      cycle();
    end
    wd = 8'hCF; clr = 1'b1;
    cycle();
    wce = 1'b0; clr = 1'b0;
    checks++; if ({o0, o1} !== 2'b11) begin errors++; $display("FAIL clear_vs_event got=%b exp=11", {o0, o1}); end
    clr = 1'b1;
    cycle();
    clr = 1'b0;
  endtask

  task automatic test_push_pop_full();
    logic [7:0] nh0, nh1;
    nh0 = q[0][1];
    nh1 = q[1][1];
    wce = 1'b1; rce = 1'b1; wd = 8'hD6;
    cycle();
    wce = 1'b0; rce = 1'b0;
    checks++; if (rd0 !== nh0 || rd1 !== nh1) begin errors++; $display("FAIL pp_full_head got=%h/%h exp=%h/%h", rd0, rd1, nh0, nh1); end
    checks++; if (l0 !== 3'd4 || l1 !== 3'd4 || {f0, f1} !== 2'b11) begin errors++; $display("FAIL pp_full_level got=%0d/%0d exp=4/4", l0, l1); end
    checks++; if ({o0, o1} !== 2'b00) begin errors++; $display("FAIL pp_full_ovf got=%b exp=00", {o0, o1}); end
  endtask

  task automatic test_random();
    reset = 1'b0;
    model_clear();
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int n = 0; n < 400; n++) begin
      wce = ($urandom_range(0, 99) < 60);
      rce = ($urandom_range(0, 99) < 45);
      clr = ($urandom_range(0, 99) < 6);
      wd  = 8'($urandom);
      cycle();
      for (int k = 0; k < 2; k++) begin
        logic [7:0] a_rd;
        logic [2:0] a_l;
        logic [3:0] a_fl;
        int sz;
        sz   = q[k].size();
        a_rd = (k == 0) ? rd0 : rd1;
        a_l  = (k == 0) ? l0 : l1;
        a_fl = (k == 0) ? {e0, f0, af0, o0} : {e1, f1, af1, o1};
        checks++; if (a_rd !== exp_head(k)) begin errors++; $display("FAIL rnd_rdata u%0d cyc%0d got=%h exp=%h", k, n, a_rd, exp_head(k)); end
        checks++; if (a_l !== 3'(sz)) begin errors++; $display("FAIL rnd_level u%0d cyc%0d got=%0d exp=%0d", k, n, a_l, sz); end
        checks++; if (a_fl !== {sz == 0, sz == DEPTH, sz >= AFL, mo[k]}) begin errors++; $display("FAIL rnd_flags u%0d cyc%0d got=%b exp=%b", k, n, a_fl, {sz == 0, sz == DEPTH, sz >= AFL, mo[k]}); end
`ifdef RINGBUFFER_FIFO_DROPCNT_EN
        checks++; if (((k == 0) ? dc0 : dc1) !== 16'(md[k])) begin errors++; $display("FAIL rnd_dropcnt u%0d cyc%0d got=%0d exp=%0d", k, n, ((k == 0) ? dc0 : dc1), md[k]); end
`endif
      end
    end
    wce = 1'b0; rce = 1'b0; clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    wce = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wd = 8'($urandom);
      cycle();
    end
    wce = 1'b0;
    reset = 1'b0;
    #1;
    checks++; if ({e0, e1} !== 2'b11) begin errors++; $display("FAIL midrst_empty got=%b exp=11", {e0, e1}); end
    checks++; if ({l0, l1} !== 6'd0) begin errors++; $display("FAIL midrst_level got=%0d/%0d exp=0/0", l0, l1); end
    checks++; if ({rd0, rd1} !== 16'h0000) begin errors++; $display("FAIL midrst_rdata got=%h/%h exp=00/00", rd0, rd1); end
    checks++; if ({f0, f1, af0, af1, o0, o1} !== 6'b000000) begin errors++; $display("FAIL midrst_flags got=%b exp=000000", {f0, f1, af0, af1, o0, o1}); end
`ifdef RINGBUFFER_FIFO_DROPCNT_EN
    checks++; if (dc0 !== 16'd0 || dc1 !== 16'd0) begin errors++; $display("FAIL midrst_dropcnt got=%0d/%0d exp=0/0", dc0, dc1); end
`endif
    model_clear();
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_policy();
    test_clear();
    test_push_pop_full();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
